// File: rtl/ysyx_23060191_mem_arbiter.sv
// Two-requester (IFU/LSU) memory arbiter with a single outstanding transaction.
// Round-robin grant on ties, a timeout on the memory response, and one-cycle
// response pulses back to the requester that owns the transaction.
module ysyx_23060191_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   // IFU
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   output logic                ifu_resp_err,
   // LSU
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                lsu_resp_err,
   // Memory
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   localparam int unsigned MASK_W = DATA_W / 8;
   // Counter value in the last permitted WAIT cycle.
   localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic                last_lsu_q, last_lsu_d;   // 1: LSU was granted last
   logic                owner_lsu_q, owner_lsu_d; // 1: LSU owns the transaction
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                err_q, err_d;
   logic [15:0]         cnt_q, cnt_d;

   logic grant_ifu, grant_lsu;
   logic in_issue, in_resp;

   // Pick the winner while idle; a tie goes to whoever was not granted last.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state_q == StIdle) begin
         if (ifu_req_valid && lsu_req_valid) begin
            grant_ifu = last_lsu_q;
            grant_lsu = !last_lsu_q;
         end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
         end
      end
   end

   // Readys are gated by rstn so they drop immediately while reset is held.
   assign ifu_req_ready = rstn & grant_ifu;
   assign lsu_req_ready = rstn & grant_lsu;

   // Next-state and datapath capture.
   always_comb begin
      state_d     = state_q;
      last_lsu_d  = last_lsu_q;
      owner_lsu_d = owner_lsu_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      data_d      = data_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         StIdle: begin
            if (grant_ifu) begin
               addr_d      = ifu_addr;
               wen_d       = 1'b0;
               wdata_d     = '0;
               wmask_d     = '0;
               owner_lsu_d = 1'b0;
               last_lsu_d  = 1'b0;
               state_d     = StIssue;
            end else if (grant_lsu) begin
               addr_d      = lsu_addr;
               wen_d       = lsu_wen;
               wdata_d     = lsu_wdata;
               wmask_d     = lsu_wmask;
               owner_lsu_d = 1'b1;
               last_lsu_d  = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            // A response in the final cycle beats the timeout.
            if (mem_resp_valid) begin
               data_d  = mem_resp_data;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == LAST_CNT) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and transaction registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         last_lsu_q  <= 1'b1;
         owner_lsu_q <= 1'b0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_lsu_q  <= last_lsu_d;
         owner_lsu_q <= owner_lsu_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         data_q      <= data_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_issue = (state_q == StIssue);
   assign in_resp  = (state_q == StResp);

   // Memory request fields are only driven while issuing.
   assign mem_req_valid = in_issue;
   assign mem_addr      = in_issue ? addr_q  : '0;
   assign mem_wen       = in_issue & wen_q;
   assign mem_wdata     = in_issue ? wdata_q : '0;
   assign mem_wmask     = in_issue ? wmask_q : '0;

   // Response pulse goes only to the owner; data/err are zero when not valid.
   assign ifu_resp_valid = in_resp & !owner_lsu_q;
   assign lsu_resp_valid = in_resp & owner_lsu_q;
   assign ifu_resp_data  = ifu_resp_valid ? data_q : '0;
   assign lsu_resp_data  = lsu_resp_valid ? data_q : '0;
   assign ifu_resp_err   = ifu_resp_valid & err_q;
   assign lsu_resp_err   = lsu_resp_valid & err_q;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Randomized bench for the memory arbiter. The reference model is
// transaction-level: each granted request is scheduled as a set of absolute
// cycle numbers (issue window, wait start, response cycle) derived from the
// latency and timeout rules, and the DUT outputs are compared every cycle.
module tb_ysyx_23060191_mem_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int MW     = DW / 8;
   localparam int TO     = 4;
   localparam int NCYC   = 3000;

   logic          clk = 1'b0;
   logic          rstn;
   logic          ifu_req_valid, ifu_req_ready;
   logic [AW-1:0] ifu_addr;
   logic          ifu_resp_valid, ifu_resp_err;
   logic [DW-1:0] ifu_resp_data;
   logic          lsu_req_valid, lsu_req_ready;
   logic [AW-1:0] lsu_addr;
   logic          lsu_wen;
   logic [DW-1:0] lsu_wdata;
   logic [MW-1:0] lsu_wmask;
   logic          lsu_resp_valid, lsu_resp_err;
   logic [DW-1:0] lsu_resp_data;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;

   always #5 clk = ~clk;

   ysyx_23060191_mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_resp_valid(ifu_resp_valid),
      .ifu_resp_data (ifu_resp_data),
      .ifu_resp_err  (ifu_resp_err),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid),
      .lsu_resp_data (lsu_resp_data),
      .lsu_resp_err  (lsu_resp_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: one scheduled transaction at most.
   bit            active;
   bit            last_lsu;
   int            idle_at;
   int            t_issue_start, t_issue_end, t_wait, t_mem_resp, t_resp;
   bit            t_owner_lsu, t_wen, t_exp_err;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdata, t_exp_data;
   logic [MW-1:0] t_wmask;
   bit            win_ifu, win_lsu, in_issue, rsp, release_rst;
   int            n_resets, dly_r, dly_d;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ifu_req_ready"}, 64'(ifu_req_ready), 64'd0);
      check({tag, ".lsu_req_ready"}, 64'(lsu_req_ready), 64'd0);
      check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, ".mem_wen"}, 64'(mem_wen), 64'd0);
      check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, ".mem_wmask"}, 64'(mem_wmask), 64'd0);
      check({tag, ".ifu_resp_valid"}, 64'(ifu_resp_valid), 64'd0);
      check({tag, ".ifu_resp_data"}, 64'(ifu_resp_data), 64'd0);
      check({tag, ".ifu_resp_err"}, 64'(ifu_resp_err), 64'd0);
      check({tag, ".lsu_resp_valid"}, 64'(lsu_resp_valid), 64'd0);
      check({tag, ".lsu_resp_data"}, 64'(lsu_resp_data), 64'd0);
      check({tag, ".lsu_resp_err"}, 64'(lsu_resp_err), 64'd0);
   endtask

   task automatic drive_requests();
      ifu_req_valid = ($urandom % 10) < 6;
      lsu_req_valid = ($urandom % 10) < 6;
      ifu_addr      = $urandom;
      lsu_addr      = $urandom;
      lsu_wen       = 1'($urandom);
      lsu_wdata     = $urandom;
      lsu_wmask     = MW'($urandom);
   endtask

   // Memory side: ready/response timing follows the scheduled transaction,
   // anything outside its windows is random noise that must be ignored.
   task automatic drive_memory();
      if (active && cyc >= t_issue_start && cyc <= t_issue_end)
         mem_req_ready = (cyc == t_issue_end);
      else
         mem_req_ready = 1'($urandom);
      if (active && cyc >= t_wait && cyc < t_resp) begin
         mem_resp_valid = (cyc == t_mem_resp);
         mem_resp_data  = (cyc == t_mem_resp) ? t_rdata : $urandom;
      end else begin
         mem_resp_valid = ($urandom % 4) == 0;
         mem_resp_data  = $urandom;
      end
   endtask

   task automatic check_cycle();
      bit idle;
      idle    = !active;
      win_ifu = 1'b0;
      win_lsu = 1'b0;
      if (idle) begin
         if (ifu_req_valid && lsu_req_valid) begin
            win_ifu = last_lsu;
            win_lsu = !last_lsu;
         end else begin
            win_ifu = ifu_req_valid;
            win_lsu = lsu_req_valid;
         end
      end
      in_issue = active && cyc >= t_issue_start && cyc <= t_issue_end;
      rsp      = active && cyc == t_resp;
      check("ifu_req_ready", 64'(ifu_req_ready), 64'(win_ifu));
      check("lsu_req_ready", 64'(lsu_req_ready), 64'(win_lsu));
      check("mem_req_valid", 64'(mem_req_valid), 64'(in_issue));
      check("mem_addr", 64'(mem_addr), in_issue ? 64'(t_addr) : 64'd0);
      check("mem_wen", 64'(mem_wen), 64'(in_issue && t_wen));
      check("mem_wdata", 64'(mem_wdata), in_issue ? 64'(t_wdata) : 64'd0);
      check("mem_wmask", 64'(mem_wmask), in_issue ? 64'(t_wmask) : 64'd0);
      check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(rsp && !t_owner_lsu));
      check("ifu_resp_data", 64'(ifu_resp_data),
            (rsp && !t_owner_lsu) ? 64'(t_exp_data) : 64'd0);
      check("ifu_resp_err", 64'(ifu_resp_err), 64'(rsp && !t_owner_lsu && t_exp_err));
      check("lsu_resp_valid", 64'(lsu_resp_valid), 64'(rsp && t_owner_lsu));
      check("lsu_resp_data", 64'(lsu_resp_data),
            (rsp && t_owner_lsu) ? 64'(t_exp_data) : 64'd0);
      check("lsu_resp_err", 64'(lsu_resp_err), 64'(rsp && t_owner_lsu && t_exp_err));
   endtask

   // Schedule a granted transaction in absolute cycles.
   task automatic schedule();
      active        = 1'b1;
      t_owner_lsu   = win_lsu;
      t_addr        = win_lsu ? lsu_addr : ifu_addr;
      t_wen         = win_lsu ? lsu_wen : 1'b0;
      t_wdata       = win_lsu ? lsu_wdata : '0;
      t_wmask       = win_lsu ? lsu_wmask : '0;
      last_lsu      = win_lsu;
      dly_r         = ($urandom % 2) ? 0 : int'($urandom_range(1, 3));
      t_issue_start = cyc + 1;
      t_issue_end   = cyc + 1 + dly_r;
      t_wait        = t_issue_end + 1;
      dly_d         = int'($urandom_range(0, TO + 1));
      t_rdata       = $urandom;
      if (dly_d < TO) begin
         t_mem_resp = t_wait + dly_d;
         t_resp     = t_mem_resp + 1;
         t_exp_data = t_rdata;
         t_exp_err  = 1'b0;
      end else begin
         t_mem_resp = -1;
         t_resp     = t_wait + TO;
         t_exp_data = '0;
         t_exp_err  = 1'b1;
      end
      idle_at = t_resp + 1;
   endtask

   initial begin
      rstn           = 1'b0;
      ifu_req_valid  = 1'b1;
      lsu_req_valid  = 1'b1;
      ifu_addr       = 32'h8000_0000;
      lsu_addr       = 32'h8000_0100;
      lsu_wen        = 1'b1;
      lsu_wdata      = 32'hDEAD_BEEF;
      lsu_wmask      = 4'hF;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0010_0093;
      active         = 1'b0;
      last_lsu       = 1'b1;
      idle_at        = 0;
      t_issue_start  = -10;
      t_issue_end    = -10;
      t_wait         = -10;
      t_mem_resp     = -10;
      t_resp         = -10;
      release_rst    = 1'b0;
      n_resets       = 0;
      #2;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      check_all_zero("reset_edge");
      rstn = 1'b1;

      for (int i = 0; i < NCYC; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         if (release_rst) begin
            rstn        = 1'b1;
            release_rst = 1'b0;
         end
         if (active && cyc >= idle_at) active = 1'b0;
         drive_requests();
         drive_memory();
         @(negedge clk);
         check_cycle();
         if (active && cyc >= t_wait && cyc < t_resp && n_resets < 4 &&
             ($urandom % 6) == 0) begin
            // Asynchronous reset while waiting on memory: abort silently.
            #1;
            ifu_req_valid = 1'b1;
            rstn          = 1'b0;
            #1;
            check_all_zero("midreset");
            active      = 1'b0;
            last_lsu    = 1'b1;
            release_rst = 1'b1;
            n_resets++;
         end else if (win_ifu || win_lsu) begin
            schedule();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_23060191_mem_arbiter.md
YSYX_23060191_MEM_ARBITER -- requirements
Module: ysyx_23060191_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-002 SHALL have parameter DATA_W, default 32 (CPU_WIDTH), meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, range 1..65535, meaning the maximum number of cycles spent in WAIT before an error response.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on the posedge.
REQ-005 SHALL have port rstn  in  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have IFU ports:
- ifu_req_valid  in  1
- ifu_req_ready  out  1
- ifu_addr  in  ADDR_W
- ifu_resp_valid  out  1
- ifu_resp_data  out  DATA_W
- ifu_resp_err  out  1
REQ-007 SHALL have LSU ports:
- lsu_req_valid  in  1
- lsu_req_ready  out  1
- lsu_addr  in  ADDR_W
- lsu_wen  in  1
- lsu_wdata  in  DATA_W
- lsu_wmask  in  DATA_W/8
- lsu_resp_valid  out  1
- lsu_resp_data  out  DATA_W
- lsu_resp_err  out  1
REQ-008 SHALL have memory ports:
- mem_req_valid  out  1
- mem_req_ready  in  1
- mem_addr  out  ADDR_W
- mem_wen  out  1
- mem_wdata  out  DATA_W
- mem_wmask  out  DATA_W/8
- mem_resp_valid  in  1
- mem_resp_data  in  DATA_W

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with at most one transaction in flight.
REQ-010 In IDLE, a requester with req_valid high SHALL be the winner; if both are high, the winner SHALL be the requester not granted last (round-robin); last-granted SHALL reset to LSU, so IFU wins the first tie.
REQ-011 req_ready SHALL be combinational: high only for the winner, only in IDLE; the other requester's ready and both readys outside IDLE SHALL be 0.
REQ-012 On a req_valid&&req_ready handshake, the block SHALL:
- register addr, wen, wdata and wmask (IFU: wen=0, wdata=0, wmask=0);
- record the owner;
- update last-granted;
- go to ISSUE.
REQ-013 In ISSUE, mem_req_valid SHALL be 1 and the mem_* fields SHALL be driven from the registers; on mem_req_ready it SHALL go to WAIT; otherwise it SHALL hold mem_req_valid and the fields stable.
REQ-014 Outside ISSUE, mem_req_valid SHALL be 0 and mem_wen SHALL be 0.
REQ-015 In WAIT, on mem_resp_valid the block SHALL capture mem_resp_data, clear the error flag and go to RESP.
REQ-016 In WAIT, a 16-bit counter SHALL count cycles from 0; if it reaches TIMEOUT without mem_resp_valid, data SHALL be set to 0, the error flag set, and the FSM go to RESP; the counter SHALL clear on entry to WAIT.
REQ-017 If mem_resp_valid coincides with the timeout cycle, the response SHALL win (no error).
REQ-018 In RESP, the owner's resp_valid SHALL be high for exactly one cycle, with resp_data and resp_err from the registers; then the FSM SHALL return to IDLE.
REQ-019 Requesters cannot back-pressure responses.
REQ-020 The non-owner's resp_valid SHALL stay 0; the resp_data/resp_err outputs SHALL be 0 whenever the corresponding resp_valid is 0.
REQ-021 Writes (wen=1) SHALL also produce a response, with data equal to the captured mem_resp_data.
REQ-022 mem_resp_valid outside WAIT SHALL be ignored, with no state change.
REQ-023 Minimum latency SHALL be: handshake at cycle T, mem_req_valid at T+1, earliest mem_resp_valid at T+2, resp_valid at T+3, IDLE again at T+4 (new handshake possible at T+4).
REQ-024 Request inputs SHALL be sampled only on the handshake cycle; changes afterwards SHALL have no effect.

Reset
REQ-025 rstn low SHALL immediately (asynchronously) force:
- FSM to IDLE;
- last-granted to LSU;
- counter, registers and error flag to 0;
- all outputs to 0, including readys, mem_req_valid and resp_valid.
REQ-026 Reset asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort the transaction with no response issued.
REQ-027 After rstn deasserts, the first posedge SHALL evaluate IDLE normally.

Verification
REQ-028 IFU read alone: ifu_addr=0x8000_0000, mem_req_ready=1, mem_resp_valid one cycle after issue with data 0x0010_0093 -> ifu_resp_valid pulses at T+3 with data 0x0010_0093, err=0; lsu_resp_valid stays 0.
REQ-029 Simultaneous requests after reset, both held valid -> grant order IFU, LSU, IFU, LSU; each response goes to the correct owner.
REQ-030 LSU write addr=0x8000_0100, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low 3 cycles -> mem_req_valid held 4 cycles with stable fields and mem_wen=1; then lsu_resp_valid pulses once.
REQ-031 TIMEOUT=4, memory never responds -> owner resp_valid pulses with err=1 and data=0, 4 cycles after entering WAIT; a stray mem_resp_valid afterwards in IDLE is ignored.
REQ-032 rstn pulled low while in WAIT -> all outputs go to 0 without waiting for a clock edge; no resp_valid pulse follows; the next IFU request completes normally.
